// File: rtl/nibble_serial_adder_if.sv
// Handshake bundle for the nibble-serial adder: operand channel in, result channel out.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    // Operand source / result sink side
    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice reused once per
// nibble, LSB nibble first, with the carry registered between passes.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBBLES - 1);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NIB_W-1:0]   nib_cnt_q, nib_cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               out_valid_q, out_valid_d;

    logic [3:0]         slice_a;
    logic [3:0]         slice_b;
    logic [4:0]         slice_res;

    // 4-bit carry-lookahead slice: every carry is a flat sum of products of
    // generate/propagate terms, so no carry ripples inside the slice.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Select the nibble pair addressed by the pass counter and run it through the slice
    always_comb begin
        slice_a = 4'h0;
        slice_b = 4'h0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (nib_cnt_q == NIB_W'(k)) begin
                slice_a = a_q[4*k +: 4];
                slice_b = b_q[4*k +: 4];
            end
        end
        slice_res = cla4(slice_a, slice_b, carry_q);
    end

    // Next-state and datapath update for the IDLE -> ADD -> DONE sequence
    always_comb begin
        state_d     = state_q;
        nib_cnt_d   = nib_cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    carry_d   = bus.c_in;
                    nib_cnt_d = '0;
                    state_d   = ADD;
                end
            end
            ADD: begin
                for (int k = 0; k < NIBBLES; k++) begin
                    if (nib_cnt_q == NIB_W'(k)) begin
                        sum_d[4*k +: 4] = slice_res[3:0];
                    end
                end
                carry_d   = slice_res[4];
                nib_cnt_d = nib_cnt_q + 1'b1;
                if (nib_cnt_q == LAST_NIB) begin
                    c_out_d     = slice_res[4];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // Result is held until the sink takes it; new operands wait for IDLE.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            nib_cnt_q   <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            nib_cnt_q   <= nib_cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;

endmodule
